// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signal bundle for load_store_unit.
// The LSU connects through the slave modport. The pipeline and memory side
// (or a bench) connects through the master modport.
interface load_store_unit_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    // pipeline request
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_req_we;
    logic [2:0]        ls_req_funct3;
    logic [31:0]       ls_req_addr;
    logic [DWIDTH-1:0] ls_req_wdata;
    // pipeline response
    logic              ls_rsp_valid;
    logic [DWIDTH-1:0] ls_rsp_rdata;
    logic              ls_rsp_err;
    // data memory port (word granular, registered read data)
    logic              ls_dm_we;
    logic              ls_dm_re;
    logic [AWIDTH-1:0] ls_dm_addr;
    logic [DWIDTH-1:0] ls_dm_wdata;
    logic [DWIDTH-1:0] ls_dm_rdata;

    modport slave (
        input  ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
        output ls_req_ready,
        output ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        output ls_dm_we, ls_dm_re, ls_dm_addr, ls_dm_wdata,
        input  ls_dm_rdata
    );

    modport master (
        output ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
        input  ls_req_ready,
        input  ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        input  ls_dm_we, ls_dm_re, ls_dm_addr, ls_dm_wdata,
        output ls_dm_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit in front of a word-wide data
// memory. It handles one RV32 byte-addressed request at a time. Sub-word stores
// become read-modify-write. Load data is sign- or zero-extended.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When it is defined, misaligned
// halfword/word accesses are rejected with an error. When it is undefined,
// the low address bits below the access size are ignored.
module load_store_unit #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic                ls_clk,
    input  logic                ls_rst,
    load_store_unit_if.slave    lsu_if
);

`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic MISALIGN_CHECK = 1'b1;
`else
    localparam logic MISALIGN_CHECK = 1'b0;
`endif

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    // Request is illegal (bad funct3) or misaligned (only when checking is on).
    function automatic logic f_req_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic illegal_s;
        logic misalign_s;
        if (we) begin
            illegal_s = (f3 > F3_W);
        end else begin
            illegal_s = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        case (f3[1:0])
            2'b01:   misalign_s = a[0];
            2'b10:   misalign_s = (a != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        return illegal_s | (misalign_s & MISALIGN_CHECK);
    endfunction

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] f_load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [31:0] word);
        logic [31:0] shifted_s;
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        shifted_s = word >> {a, 3'b000};
        byte_s    = shifted_s[7:0];
        if (a[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (f3)
            F3_B:    return {{24{byte_s[7]}}, byte_s};
            F3_H:    return {{16{half_s[15]}}, half_s};
            F3_W:    return word;
            F3_BU:   return {24'h00_0000, byte_s};
            F3_HU:   return {16'h0000, half_s};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Replace the addressed byte or halfword of a memory word with store data.
    function automatic logic [31:0] f_store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] merged_s;
        merged_s = word;
        case (f3)
            F3_B: begin
                case (a)
                    2'b00:   merged_s[7:0]   = wd[7:0];
                    2'b01:   merged_s[15:8]  = wd[7:0];
                    2'b10:   merged_s[23:16] = wd[7:0];
                    2'b11:   merged_s[31:24] = wd[7:0];
                    default: merged_s        = word;
                endcase
            end
            F3_H: begin
                if (a[1]) begin
                    merged_s[31:16] = wd[15:0];
                end else begin
                    merged_s[15:0]  = wd[15:0];
                end
            end
            default: merged_s = word;
        endcase
        return merged_s;
    endfunction

    state_t              r_state;
    state_t              w_next_state;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [AWIDTH+1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic [DWIDTH-1:0]   r_merge;
    logic [DWIDTH-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_req_err;
    logic                w_ready;
    logic                w_dm_re;
    logic                w_dm_we;
    logic                w_rsp_valid;
    logic [DWIDTH-1:0]   w_dm_wdata;

    assign w_accept  = lsu_if.ls_req_valid && w_ready;
    assign w_req_err = f_req_err(lsu_if.ls_req_we, lsu_if.ls_req_funct3, lsu_if.ls_req_addr[1:0]);

    // State register; reset aborts any access in flight with no response.
    always_ff @(posedge ls_clk or posedge ls_rst) begin
        if (ls_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing: error -> RESP, SW -> WR, loads and SB/SH -> RD.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_accept) begin
                    w_next_state = S_IDLE;
                end else if (w_req_err) begin
                    w_next_state = S_RESP;
                end else if (lsu_if.ls_req_we && (lsu_if.ls_req_funct3 == F3_W)) begin
                    w_next_state = S_WR;
                end else begin
                    w_next_state = S_RD;
                end
            end
            S_RD:   w_next_state = S_CAP;
            S_CAP: begin
                if (r_we) begin
                    w_next_state = S_WR;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_WR:   w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake and memory strobes decoded from the state register only, so
    // reset removes dm_we/dm_re in the same cycle it is asserted.
    always_comb begin
        w_ready     = 1'b0;
        w_dm_re     = 1'b0;
        w_dm_we     = 1'b0;
        w_rsp_valid = 1'b0;
        w_dm_wdata  = {DWIDTH{1'b0}};
        case (r_state)
            S_IDLE: w_ready = 1'b1;
            S_RD:   w_dm_re = 1'b1;
            S_CAP:  w_ready = 1'b0;
            S_WR: begin
                w_dm_we = 1'b1;
                if (r_funct3 == F3_W) begin
                    w_dm_wdata = r_wdata;
                end else begin
                    w_dm_wdata = r_merge;
                end
            end
            S_RESP: w_rsp_valid = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Request capture on acceptance; lane extract or merge when read data lands.
    always_ff @(posedge ls_clk or posedge ls_rst) begin
        if (ls_rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= {(AWIDTH+2){1'b0}};
            r_wdata     <= {DWIDTH{1'b0}};
            r_merge     <= {DWIDTH{1'b0}};
            r_rsp_rdata <= {DWIDTH{1'b0}};
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_we        <= lsu_if.ls_req_we;
            r_funct3    <= lsu_if.ls_req_funct3;
            r_addr      <= lsu_if.ls_req_addr[AWIDTH+1:0];
            r_wdata     <= lsu_if.ls_req_wdata;
            r_rsp_rdata <= {DWIDTH{1'b0}};
            r_rsp_err   <= w_req_err;
        end else if (r_state == S_CAP) begin
            if (r_we) begin
                r_merge <= f_store_merge(r_funct3, r_addr[1:0], lsu_if.ls_dm_rdata, r_wdata);
            end else begin
                r_rsp_rdata <= f_load_extend(r_funct3, r_addr[1:0], lsu_if.ls_dm_rdata);
            end
        end
    end

    assign lsu_if.ls_req_ready = w_ready;
    assign lsu_if.ls_rsp_valid = w_rsp_valid;
    assign lsu_if.ls_rsp_rdata = r_rsp_rdata;
    assign lsu_if.ls_rsp_err   = r_rsp_err;
    assign lsu_if.ls_dm_we     = w_dm_we;
    assign lsu_if.ls_dm_re     = w_dm_re;
    assign lsu_if.ls_dm_addr   = r_addr[AWIDTH+1:2];
    assign lsu_if.ls_dm_wdata  = w_dm_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. The reference model is a byte-array
// memory plus access-size arithmetic. A word-wide memory with registered read
// data is attached to the DUT.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.AWIDTH(5), .DWIDTH(32)) lsu_if ();

    load_store_unit #(.AWIDTH(5), .DWIDTH(32)) dut (
        .ls_clk (clk),
        .ls_rst (rst),
        .lsu_if (lsu_if.slave)
    );

    logic [31:0] mem [0:31];
    logic [7:0]  gb  [0:127];
    int n_pass  = 0;
    int n_total = 0;

    // data memory: synchronous write, registered read
    always @(posedge clk) begin
        if (lsu_if.ls_dm_we) mem[lsu_if.ls_dm_addr] <= lsu_if.ls_dm_wdata;
        if (lsu_if.ls_dm_re) lsu_if.ls_dm_rdata <= mem[lsu_if.ls_dm_addr];
    end

    // Reference: legality, size, alignment and byte-level memory effect.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic e_err, output logic [31:0] e_rdata,
                             output int e_lat, output int e_re, output int e_we, output logic [31:0] e_word);
        int size, base, wb;
        logic legal, mis;
        logic [31:0] v;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        mis  = (int'(addr[6:0]) % size) != 0;
`ifdef LSU_MISALIGN_CHECK_EN
        e_err = !legal || mis;
`else
        e_err = !legal;
`endif
        base = (int'(addr[6:0]) / size) * size;
        wb   = (base / 4) * 4;
        e_rdata = 32'h0; e_lat = 1; e_re = 0; e_we = 0; e_word = 32'h0;
        if (e_err) return;
        if (!we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(gb[base+i]) << (8*i));
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            e_rdata = v; e_lat = 3; e_re = 1;
        end else begin
            for (int i = 0; i < size; i++) gb[base+i] = 8'(wd >> (8*i));
            e_word = {gb[wb+3], gb[wb+2], gb[wb+1], gb[wb]};
            e_lat = (size == 4) ? 2 : 4;
            e_re  = (size == 4) ? 0 : 1;
            e_we  = 1;
        end
    endtask

    // One request: handshake, per-cycle memory-port observation, response checks.
    task automatic do_req(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd_o, output logic err_o);
        logic        e_err;
        logic [31:0] e_rdata, e_word;
        int          e_lat, e_re, e_we;
        int          lat, n_re, n_we, bad, waitc;
        logic [4:0]  e_addr;
        e_addr = addr[6:2];
        model_req(we, f3, addr, wd, e_err, e_rdata, e_lat, e_re, e_we, e_word);
        rd_o = 32'h0; err_o = 1'b0; lat = 0; n_re = 0; n_we = 0; bad = 0; waitc = 0;
        while (lsu_if.ls_req_ready !== 1'b1 && waitc < 16) begin
            @(negedge clk); waitc++;
        end
        n_total++;
        if (lsu_if.ls_req_ready !== 1'b1) begin
            $display("FAIL %s ready_wait: ready=%b required 1", name, lsu_if.ls_req_ready);
            return;
        end else n_pass++;
        lsu_if.ls_req_valid = 1'b1; lsu_if.ls_req_we = we; lsu_if.ls_req_funct3 = f3;
        lsu_if.ls_req_addr = addr; lsu_if.ls_req_wdata = wd;
        @(posedge clk); #1;
        lsu_if.ls_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lsu_if.ls_dm_re && lsu_if.ls_dm_we) bad++;
            if (lsu_if.ls_dm_re === 1'b1) begin
                n_re++;
                if (lsu_if.ls_dm_addr !== e_addr) bad++;
            end
            if (lsu_if.ls_dm_we === 1'b1) begin
                n_we++;
                if (lsu_if.ls_dm_addr !== e_addr || lsu_if.ls_dm_wdata !== e_word) bad++;
            end else if (lsu_if.ls_dm_wdata !== 32'h0) bad++;
            if (lsu_if.ls_rsp_valid === 1'b1) begin
                lat = c; rd_o = lsu_if.ls_rsp_rdata; err_o = lsu_if.ls_rsp_err;
                break;
            end
        end
        n_total++;
        if (lat !== e_lat) $display("FAIL %s latency: got %0d required %0d", name, lat, e_lat);
        else n_pass++;
        n_total++;
        if (rd_o !== e_rdata) $display("FAIL %s rdata: got %h required %h", name, rd_o, e_rdata);
        else n_pass++;
        n_total++;
        if (err_o !== e_err) $display("FAIL %s err: got %b required %b", name, err_o, e_err);
        else n_pass++;
        n_total++;
        if (n_re != e_re || n_we != e_we)
            $display("FAIL %s mem_access: re=%0d we=%0d required re=%0d we=%0d", name, n_re, n_we, e_re, e_we);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL %s mem_port: %0d bad cycles required 0 (addr %h wdata %h)", name, bad, e_addr, e_word);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (lsu_if.ls_rsp_valid !== 1'b0 || lsu_if.ls_req_ready !== 1'b1)
            $display("FAIL %s after_resp: rsp_valid=%b ready=%b required 0/1", name, lsu_if.ls_rsp_valid, lsu_if.ls_req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        lsu_if.ls_req_valid = 1'b0; lsu_if.ls_req_we = 1'b0; lsu_if.ls_req_funct3 = 3'b000;
        lsu_if.ls_req_addr = 32'h0; lsu_if.ls_req_wdata = 32'h0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({lsu_if.ls_req_ready, lsu_if.ls_rsp_valid, lsu_if.ls_rsp_err, lsu_if.ls_dm_we, lsu_if.ls_dm_re} !== 5'b10000)
            $display("FAIL reset_ctrl: rdy,vld,err,we,re=%b required 10000",
                     {lsu_if.ls_req_ready, lsu_if.ls_rsp_valid, lsu_if.ls_rsp_err, lsu_if.ls_dm_we, lsu_if.ls_dm_re});
        else n_pass++;
        n_total++;
        if (lsu_if.ls_rsp_rdata !== 32'h0 || lsu_if.ls_dm_addr !== 5'h0 || lsu_if.ls_dm_wdata !== 32'h0)
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", lsu_if.ls_rsp_rdata,
                     lsu_if.ls_dm_addr, lsu_if.ls_dm_wdata);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (lsu_if.ls_req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", lsu_if.ls_req_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic er;
        do_req("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, rd, er);
        do_req("lw08", 1'b0, 3'b010, 32'h08, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL lw08_value: got %h required deadbeef", rd); else n_pass++;
        do_req("sb09", 1'b1, 3'b000, 32'h09, 32'h000000A5, rd, er);
        n_total++;
        if (mem[2] !== 32'hDEADA5EF) $display("FAIL sb09_word: got %h required deada5ef", mem[2]); else n_pass++;
        do_req("lb09", 1'b0, 3'b000, 32'h09, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hFFFFFFA5) $display("FAIL lb09_value: got %h required ffffffa5", rd); else n_pass++;
        do_req("lbu09", 1'b0, 3'b100, 32'h09, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h000000A5) $display("FAIL lbu09_value: got %h required 000000a5", rd); else n_pass++;
        do_req("sh0a", 1'b1, 3'b001, 32'h0A, 32'h00001234, rd, er);
        n_total++;
        if (mem[2] !== 32'h1234A5EF) $display("FAIL sh0a_word: got %h required 1234a5ef", mem[2]); else n_pass++;
        do_req("lh0a", 1'b0, 3'b001, 32'h0A, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h00001234) $display("FAIL lh0a_value: got %h required 00001234", rd); else n_pass++;
        do_req("lh08", 1'b0, 3'b001, 32'h08, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hFFFFA5EF) $display("FAIL lh08_value: got %h required ffffa5ef", rd); else n_pass++;
    endtask

    task automatic test_reset_during_wr();
        logic [31:0] rd; logic er; int waitc; int seen;
        while (lsu_if.ls_req_ready !== 1'b1) @(negedge clk);
        lsu_if.ls_req_valid = 1'b1; lsu_if.ls_req_we = 1'b1; lsu_if.ls_req_funct3 = 3'b000;
        lsu_if.ls_req_addr = 32'h09; lsu_if.ls_req_wdata = 32'h0000005A;
        @(posedge clk); #1;
        lsu_if.ls_req_valid = 1'b0;
        waitc = 0;
        do begin @(negedge clk); waitc++; end while (lsu_if.ls_dm_we !== 1'b1 && waitc < 8);
        n_total++;
        if (lsu_if.ls_dm_we !== 1'b1 || waitc != 3) $display("FAIL rstwr_reach_wr: we=%b cycle=%0d required 1/3", lsu_if.ls_dm_we, waitc);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (lsu_if.ls_dm_we !== 1'b0 || lsu_if.ls_dm_re !== 1'b0 || lsu_if.ls_req_ready !== 1'b1)
            $display("FAIL rstwr_drop: we=%b re=%b ready=%b required 0/0/1", lsu_if.ls_dm_we, lsu_if.ls_dm_re, lsu_if.ls_req_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (lsu_if.ls_rsp_valid !== 1'b0 || lsu_if.ls_dm_we !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL rstwr_no_rsp: %0d cycles with rsp/we required 0", seen); else n_pass++;
        n_total++;
        if (mem[2] !== 32'h1234A5EF) $display("FAIL rstwr_word: got %h required 1234a5ef", mem[2]); else n_pass++;
        do_req("rstwr_lb09", 1'b0, 3'b000, 32'h09, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hFFFFFFA5) $display("FAIL rstwr_readback: got %h required ffffffa5", rd); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er;
        do_req("sw04", 1'b1, 3'b010, 32'h04, 32'hCAFEF00D, rd, er);
        do_req("lw06", 1'b0, 3'b010, 32'h06, 32'h0, rd, er);
`ifdef LSU_MISALIGN_CHECK_EN
        n_total++;
        if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw06_err: err=%b rdata=%h required 1/0", er, rd); else n_pass++;
`else
        n_total++;
        if (er !== 1'b0 || rd !== 32'hCAFEF00D) $display("FAIL lw06_noerr: err=%b rdata=%h required 0/cafef00d", er, rd); else n_pass++;
`endif
        do_req("sh0b", 1'b1, 3'b001, 32'h0B, 32'h0000BEEF, rd, er);
        do_req("ld_f3_011", 1'b0, 3'b011, 32'h00, 32'h0, rd, er);
        n_total++;
        if (er !== 1'b1) $display("FAIL ld_f3_011_err: got %b required 1", er); else n_pass++;
        do_req("st_f3_100", 1'b1, 3'b100, 32'h00, 32'h11223344, rd, er);
        n_total++;
        if (er !== 1'b1) $display("FAIL st_f3_100_err: got %b required 1", er); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic e1_err, e2_err; logic [31:0] e1, e2, ew; int l, r, w;
        int acc2; int got;
        model_req(1'b0, 3'b010, 32'h04, 32'h0, e1_err, e1, l, r, w, ew);
        model_req(1'b0, 3'b010, 32'h08, 32'h0, e2_err, e2, l, r, w, ew);
        while (lsu_if.ls_req_ready !== 1'b1) @(negedge clk);
        lsu_if.ls_req_valid = 1'b1; lsu_if.ls_req_we = 1'b0; lsu_if.ls_req_funct3 = 3'b010;
        lsu_if.ls_req_addr = 32'h04; lsu_if.ls_req_wdata = 32'h0;
        @(posedge clk); #1;
        lsu_if.ls_req_addr = 32'h08;
        acc2 = -1; got = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lsu_if.ls_rsp_valid === 1'b1) begin
                n_total++;
                if (got == 0) begin
                    if (c != 3 || lsu_if.ls_rsp_rdata !== e1)
                        $display("FAIL b2b_first: cycle %0d rdata %h required 3/%h", c, lsu_if.ls_rsp_rdata, e1);
                    else n_pass++;
                end else begin
                    if (c - acc2 != 3 || lsu_if.ls_rsp_rdata !== e2)
                        $display("FAIL b2b_second: lat %0d rdata %h required 3/%h", c - acc2, lsu_if.ls_rsp_rdata, e2);
                    else n_pass++;
                end
                got++;
                if (got == 2) break;
            end
            if (lsu_if.ls_req_ready === 1'b1 && acc2 < 0) begin
                acc2 = c;
                @(posedge clk); #1;
                lsu_if.ls_req_valid = 1'b0;
            end
        end
        lsu_if.ls_req_valid = 1'b0;
        n_total++;
        if (acc2 != 4 || got != 2) $display("FAIL b2b_accept: accept cycle %0d responses %0d required 4/2", acc2, got);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            do_req($sformatf("rand%0d", i), we, f3, addr, $urandom, rd, er);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        for (int i = 0; i < 128; i++) gb[i] = 8'h0;
        test_reset();
        test_directed();
        test_reset_during_wr();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly upstream of the data memory. It accepts one byte-addressed load or store request at a time from the pipeline. It converts RV32 byte and halfword accesses into word accesses, doing read-modify-write for SB/SH, and returns sign- or zero-extended load data. It drives the data memory's word-granular write-enable, read-enable, address and write-data inputs, and consumes its registered read data.

## Interface
- AWIDTH, 5, word-address width driven to data memory (memory holds 2^AWIDTH 32-bit words)
- DWIDTH, 32, data width; only 32 is supported

Ports:
- ls_clk  in  1  clock, rising-edge
- ls_rst  in  1  reset, asynchronous, active-high
- ls_req_valid  in  1  request valid
- ls_req_ready  out  1  request accepted when valid&&ready at rising edge
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_funct3  in  3  RV32 funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- ls_req_addr  in  32  byte address
- ls_req_wdata  in  32  store data, right-aligned
- ls_rsp_valid  out  1  one-cycle response pulse
- ls_rsp_rdata  out  32  extended load data; 0 for stores and errors
- ls_rsp_err  out  1  misaligned or illegal funct3
- ls_dm_we  out  1  memory write enable
- ls_dm_re  out  1  memory read enable
- ls_dm_addr  out  AWIDTH  word address = req_addr[AWIDTH+1:2]
- ls_dm_wdata  out  32  memory write data
- ls_dm_rdata  in  32  memory read data, valid the cycle after ls_dm_re

## Operation
- Request registered on acceptance. The address, funct3, we and wdata registers are held until RESP.
- States:
  - IDLE: ready=1.
  - RD: dm_re=1.
  - CAP: capture dm_rdata.
  - WR: dm_we=1.
  - RESP: rsp_valid=1.
- Transitions from IDLE on accept:
  - Error → RESP.
  - SW → WR.
  - All loads, SB and SH → RD.
- Fixed transitions: RD → CAP; WR → RESP; RESP → IDLE.
- Transitions from CAP:
  - Load → RESP. rsp_rdata register loads the extracted lane: byte lane addr[1:0], or halfword lane addr[1].
  - SB/SH → WR. Merge register loads dm_rdata with the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0].
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- ls_dm_wdata:
  - SW: registered wdata.
  - SB/SH: merge register.
  - 0 outside WR.
- dm_we and dm_re are decoded from the state register and are never both high.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Illegal funct3: load 011/110/111, store ≥011.
  - On error: no memory access, err=1, rdata=0.
- Address bits above AWIDTH+1 are ignored; accesses wrap modulo memory size.
- The response is not backpressured. rsp_valid is high exactly one cycle.

## Timing
- Reset values:
  - State IDLE, ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - dm_we=0, dm_re=0, dm_addr=0, dm_wdata=0.
  - Merge and request registers 0.
- Accept edge = cycle 0. rsp_valid is high in:
  - Load: cycle 3 (RD 1, CAP 2, RESP 3).
  - SW: cycle 2.
  - SB/SH: cycle 4 (RD 1, CAP 2, WR 3, RESP 4).
  - Error: cycle 1.
- The next request can be accepted in the cycle after RESP, when ready=1 again.
- Reset asserted in any state:
  - Forces IDLE immediately and drops dm_we/dm_re in the same cycle.
  - A WR interrupted by reset is not written.
  - The pending request is discarded and no response is issued.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned requests produce err=1 as above.
- LSU_MISALIGN_CHECK_EN undefined:
  - Alignment is not checked.
  - LH/LHU/SH use addr[1], ignoring addr[0]; LW/SW ignore addr[1:0].
  - The access proceeds normally.
  - Illegal funct3 still flags err.

## Test plan
- SW addr 0x08, wdata 0xDEADBEEF: dm_we pulses in cycle 1 with dm_addr=2 and dm_wdata=0xDEADBEEF; rsp in cycle 2, err=0. Then LW 0x08 gives rdata 0xDEADBEEF at cycle 3.
- SB addr 0x09, wdata 0x000000A5: RD then WR with dm_wdata=0xDEADA5EF. Then LB 0x09 gives 0xFFFFFFA5 and LBU 0x09 gives 0x000000A5.
- SH addr 0x0A, wdata 0x00001234: word becomes 0x1234A5EF. Then LH 0x0A gives 0x00001234 and LH 0x08 gives 0xFFFFA5EF.
- LW addr 0x06 with macro defined: rsp in cycle 1 with err=1 and rdata=0; dm_re/dm_we stay 0. Without the macro: reads word 1, err=0.
- ls_rst pulsed during the WR cycle of SB 0x09: dm_we drops in the same cycle and the word is unchanged on read-back. No rsp_valid is issued; ready=1 after reset release.
- ls_req_valid held high with two back-to-back LW requests: the second is accepted only when ready returns, 4 cycles after the first; both responses are correct.
